// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way: 2-way set-associative, write-through, read-allocate data cache controller
// sitting between the MEM stage and the SRAM controller.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN       CPU read/write requests, held until ready
//   address, write_data      CPU byte address and store data
//   read_data, ready, hit    load data, access-complete strobe, read-hit flag
//   sram_r_en, sram_w_en     SRAM line-read / word-write requests
//   sram_address             address forwarded to SRAM (line-aligned for reads)
//   sram_write_data          store data forwarded to SRAM
//   SRAM_read_data           2-word line from SRAM, word0 in the low half
//   SRAM_ready               single-cycle SRAM completion pulse
//   hit_count, miss_count    read hit/miss counters, present only with CACHE_STATS_EN
//
// Optional feature macro: CACHE_STATS_EN adds the hit/miss counters and their ports.
module cache_ctrl_2way #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SETS   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_R_EN,
    input  logic                MEM_W_EN,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   write_data,
    output logic [DATA_W-1:0]   read_data,
    output logic                ready,
    output logic                hit,
    output logic                sram_r_en,
    output logic                sram_w_en,
    output logic [ADDR_W-1:0]   sram_address,
    output logic [DATA_W-1:0]   sram_write_data,
    input  logic [2*DATA_W-1:0] SRAM_read_data,
    input  logic                SRAM_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    localparam int unsigned INDEX_W = $clog2(SETS);
    localparam int unsigned TAG_W   = ADDR_W - 3 - INDEX_W;
    localparam int unsigned LINE_W  = 2 * DATA_W;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRdMiss = 2'd1;
    localparam logic [1:0] StWrThru = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0][SETS-1:0]  valid_q, valid_d;
    // lru_q[set] names the way to evict next
    logic [SETS-1:0]       lru_q, lru_d;
    logic [TAG_W-1:0]      tag_q  [2][SETS];
    logic [LINE_W-1:0]     data_q [2][SETS];

    logic [INDEX_W-1:0]    idx;
    logic [TAG_W-1:0]      tag;
    logic                  wsel;
    logic                  match0, match1, any_match;
    logic                  hit_way, victim;
    logic [LINE_W-1:0]     hit_line;
    logic [DATA_W-1:0]     hit_word, sram_word;
    logic                  rd_req;
    logic                  fill_en, wr_hit_en;

    assign idx       = address[3 +: INDEX_W];
    assign tag       = address[ADDR_W-1 -: TAG_W];
    assign wsel      = address[2];
    assign match0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign match1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign any_match = match0 || match1;
    // way0 wins if both ever match
    assign hit_way   = match0 ? 1'b0 : 1'b1;
    assign hit_line  = data_q[hit_way][idx];
    assign hit_word  = wsel ? hit_line[LINE_W-1:DATA_W] : hit_line[DATA_W-1:0];
    assign sram_word = wsel ? SRAM_read_data[LINE_W-1:DATA_W] : SRAM_read_data[DATA_W-1:0];
    // writes take priority when both requests are raised
    assign rd_req    = MEM_R_EN && !MEM_W_EN;
    assign victim    = !valid_q[0][idx] ? 1'b0 :
                       !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        lru_d           = lru_q;
        ready           = 1'b0;
        hit             = 1'b0;
        read_data       = '0;
        sram_r_en       = 1'b0;
        sram_w_en       = 1'b0;
        sram_address    = '0;
        sram_write_data = '0;
        fill_en         = 1'b0;
        wr_hit_en       = 1'b0;
        case (state_q)
            StIdle: begin
                if (MEM_W_EN) begin
                    wr_hit_en = any_match;
                    state_d   = StWrThru;
                end else if (rd_req) begin
                    if (any_match) begin
                        hit             = 1'b1;
                        ready           = 1'b1;
                        read_data       = hit_word;
                        lru_d[idx]      = ~hit_way;
                    end else begin
                        state_d = StRdMiss;
                    end
                end
            end
            StRdMiss: begin
                sram_r_en    = 1'b1;
                sram_address = {address[ADDR_W-1:3], 3'b000};
                if (SRAM_ready) begin
                    fill_en                 = 1'b1;
                    valid_d[victim][idx]    = 1'b1;
                    lru_d[idx]              = ~victim;
                    ready                   = 1'b1;
                    read_data               = sram_word;
                    state_d                 = StIdle;
                end
            end
            StWrThru: begin
                sram_w_en       = 1'b1;
                sram_address    = address;
                sram_write_data = write_data;
                if (SRAM_ready) begin
                    ready   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            lru_q   <= lru_d;
        end
    end

    // Tag/data storage is never cleared; reset only blocks an in-flight fill or store.
    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            tag_q[victim][idx]  <= tag;
            data_q[victim][idx] <= SRAM_read_data;
        end else if (!rst && wr_hit_en) begin
            if (wsel) begin
                data_q[hit_way][idx][LINE_W-1:DATA_W] <= write_data;
            end else begin
                data_q[hit_way][idx][DATA_W-1:0] <= write_data;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, hit};
        miss_count_d = miss_count_q +
                       {31'd0, (state_q == StIdle) && rd_req && !any_match};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// tb_cache_ctrl_2way: randomized self-checking bench for cache_ctrl_2way.
// Reference: a word-addressed backing memory plus, per set, a recency-ordered list of
// cached tags (front = most recently used, at most two entries).
module tb_cache_ctrl_2way;

    localparam int unsigned SETS    = 64;
    localparam int unsigned INDEX_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] address, write_data, read_data;
    logic        ready, hit, sram_r_en, sram_w_en;
    logic [31:0] sram_address, sram_write_data;
    logic [63:0] SRAM_read_data;
    logic        SRAM_ready;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_ctrl_2way #(.ADDR_W(32), .DATA_W(32), .SETS(SETS)) dut (
        .clk             (clk),
        .rst             (rst),
        .MEM_R_EN        (MEM_R_EN),
        .MEM_W_EN        (MEM_W_EN),
        .address         (address),
        .write_data      (write_data),
        .read_data       (read_data),
        .ready           (ready),
        .hit             (hit),
        .sram_r_en       (sram_r_en),
        .sram_w_en       (sram_w_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_ready      (SRAM_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [int unsigned];
    logic [31:0] m_tag [SETS][2];
    int          m_cnt [SETS];
    logic [31:0] exp_hits, exp_misses;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int unsigned wa);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic int model_find(input int unsigned set, input logic [31:0] tg);
        for (int i = 0; i < m_cnt[set]; i++) if (m_tag[set][i] == tg) return i;
        return -1;
    endfunction

    task automatic model_use(input int unsigned set, input int pos);
        logic [31:0] t;
        if (pos == 1) begin
            t = m_tag[set][1];
            m_tag[set][1] = m_tag[set][0];
            m_tag[set][0] = t;
        end
    endtask

    // New line becomes most recent; the least recent drops off a full set.
    task automatic model_fill(input int unsigned set, input logic [31:0] tg);
        m_tag[set][1] = m_tag[set][0];
        m_tag[set][0] = tg;
        if (m_cnt[set] < 2) m_cnt[set]++;
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_idle_ready"}, {63'd0, ready}, 64'd0);
        check_val({tag, "_idle_hit"}, {63'd0, hit}, 64'd0);
        check_val({tag, "_idle_rdata"}, {32'd0, read_data}, 64'd0);
        check_val({tag, "_idle_sram"}, {62'd0, sram_r_en, sram_w_en}, 64'd0);
    endtask

    task automatic access(input logic re, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int unsigned set, wa, la, lat;
        logic [31:0] tg;
        int          pos;
        set = (addr >> 3) & (SETS - 1);
        tg  = addr >> (3 + INDEX_W);
        wa  = addr >> 2;
        la  = (addr >> 3) << 1;
        pos = model_find(set, tg);
        lat = $urandom_range(0, 3);
        @(posedge clk); #1;
        MEM_R_EN = re; MEM_W_EN = we; address = addr; write_data = wdata;
        #1;
        if (!we && re && pos >= 0) begin
            check_val("rd_hit_flag", {63'd0, hit}, 64'd1);
            check_val("rd_hit_ready", {63'd0, ready}, 64'd1);
            check_val("rd_hit_data", {32'd0, read_data}, {32'd0, mem_rd(wa)});
            model_use(set, pos);
            exp_hits++;
        end else begin
            check_val("req_hit_flag", {63'd0, hit}, 64'd0);
            check_val("req_ready", {63'd0, ready}, 64'd0);
            if (!we) exp_misses++;
            for (int i = 0; i <= int'(lat); i++) begin
                @(posedge clk); #1;
                SRAM_ready     = (i == int'(lat));
                SRAM_read_data = SRAM_ready ? {mem_rd(la + 1), mem_rd(la)} : {$urandom, $urandom};
                #1;
                check_val("busy_ready", {63'd0, ready}, {63'd0, SRAM_ready});
                if (we) begin
                    check_val("wr_sram_en", {62'd0, sram_r_en, sram_w_en}, 64'd1);
                    check_val("wr_sram_addr", {32'd0, sram_address}, {32'd0, addr});
                    check_val("wr_sram_data", {32'd0, sram_write_data}, {32'd0, wdata});
                end else begin
                    check_val("rd_sram_en", {62'd0, sram_r_en, sram_w_en}, 64'd2);
                    check_val("rd_sram_addr", {32'd0, sram_address},
                              {32'd0, addr & 32'hFFFF_FFF8});
                    if (SRAM_ready)
                        check_val("rd_miss_data", {32'd0, read_data}, {32'd0, mem_rd(wa)});
                end
            end
            if (we) mem[wa] = wdata;
            else    model_fill(set, tg);
        end
        @(posedge clk); #1;
        SRAM_ready = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        #1;
        check_idle("post");
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
        check_val({tag, "_hit_count"}, {32'd0, hit_count}, {32'd0, exp_hits});
        check_val({tag, "_miss_count"}, {32'd0, miss_count}, {32'd0, exp_misses});
`else
        if (tag.len() == 0) $display("empty stats tag");
`endif
    endtask

    initial begin
        logic [31:0] a;
        int unsigned op;
        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; write_data = '0;
        SRAM_read_data = '0; SRAM_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; #1;
        check_idle("reset");
        check_stats("reset");

        // Directed: fill with known line, then hit
        mem[32'h400 >> 2] = 32'hAAAA;
        mem[32'h404 >> 2] = 32'hBBBB;
        access(1'b1, 1'b0, 32'h404, 0);
        access(1'b1, 1'b0, 32'h404, 0);
        // LRU eviction within set 0
        access(1'b1, 1'b0, 32'hC00, 0);
        access(1'b1, 1'b0, 32'h400, 0);
        access(1'b1, 1'b0, 32'h1400, 0);
        access(1'b1, 1'b0, 32'h400, 0);
        access(1'b1, 1'b0, 32'hC00, 0);
        check_stats("directed");
        // Write hit, write miss (no allocate), simultaneous request
        access(1'b0, 1'b1, 32'h400, 32'h1234);
        access(1'b1, 1'b0, 32'h400, 0);
        access(1'b0, 1'b1, 32'h2000, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 32'h2000, 0);
        access(1'b1, 1'b1, 32'h404, 32'h5678);
        access(1'b1, 1'b0, 32'h404, 0);

        // Stray SRAM_ready in IDLE must be ignored
        @(posedge clk); #1; SRAM_ready = 1'b1; #1;
        check_idle("stray_ready");
        @(posedge clk); #1; SRAM_ready = 1'b0; #1;
        check_idle("stray_after");

        // Reset in the middle of a read miss
        @(posedge clk); #1; MEM_R_EN = 1'b1; address = 32'h8008;
        @(posedge clk); #1;
        check_val("rst_mid_sram_r", {63'd0, sram_r_en}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; MEM_R_EN = 1'b0; #1;
        model_reset();
        check_idle("rst_mid");
        check_stats("rst_mid");
        access(1'b1, 1'b0, 32'h8008, 0);
        access(1'b1, 1'b0, 32'h404, 0);

        // Randomized traffic over a small tag/set pool to force conflicts
        for (int n = 0; n < 400; n++) begin
            a  = ($urandom_range(0, 3) << (3 + INDEX_W)) | ($urandom_range(0, 3) << 3) |
                 ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            op = $urandom_range(0, 99);
            if (op < 70)      access(1'b1, 1'b0, a, 0);
            else if (op < 95) access(1'b0, 1'b1, a, $urandom);
            else              access(1'b1, 1'b1, a, $urandom);
        end
        check_stats("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
